// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid channel,
// branch redirect input from execute, and the valid/ready instruction
// stream toward decode. The master modport is the fetch stage; the slave
// modport is its environment (memory, execute, decode).
interface fetch_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  // Instruction memory channel
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_gnt;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Branch redirect from execute
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  // Instruction stream toward decode
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic [ADDR_W-1:0]  if_pc_plus4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output if_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch front end. Holds the PC, issues at most one outstanding
// word read to instruction memory, buffers returned instructions in a
// 2-entry FIFO and hands them to decode with valid/ready. A redirect from
// execute retargets the PC and throws away everything fetched or in flight.
module fetch_stage #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active-low
  fetch_stage_if.master bus
);

  localparam logic [ADDR_W-1:0] PC_STEP    = {{(ADDR_W-3){1'b0}}, 3'b100};
  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // one cycle after reset release, nothing issued
    ST_REQ  = 2'd1,  // presenting a request when the FIFO has room
    ST_WAIT = 2'd2,  // request granted, waiting for its data
    ST_DROP = 2'd3   // request granted but made stale by a redirect
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pc_inc_s;
  logic [ADDR_W-1:0]  redirect_tgt_s;
  logic               imem_req_q, imem_req_d;
  logic               if_valid_q, if_valid_d;

  // FIFO storage: instruction, its address, and its address + 4
  logic [INSTR_W-1:0] fifo_instr_q [2];
  logic [ADDR_W-1:0]  fifo_pc_q    [2];
  logic [ADDR_W-1:0]  fifo_pc4_q   [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;

  logic               grant_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic               redirect_s;

  // Wrapping increment and target alignment; both modulo 2^ADDR_W
  assign pc_inc_s       = pc_q + PC_STEP;
  assign redirect_tgt_s = bus.redirect_pc & ALIGN_MASK;

  // A grant only counts while a request is actually being presented
  assign grant_s    = imem_req_q & bus.imem_gnt;
  assign redirect_s = bus.redirect_valid;
  assign pop_s      = if_valid_q & bus.if_ready;

  // Fetch control: next state, PC update, push and flush decisions
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    flush_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // rvalid and redirect are both ignored here
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (grant_s) begin
          if (redirect_s) begin
            state_d = ST_DROP;
          end else begin
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (bus.imem_rvalid) begin
          state_d = ST_REQ;
          if (redirect_s) begin
            push_s = 1'b0;
          end else begin
            push_s = 1'b1;
            pc_d   = pc_inc_s;
          end
        end else if (redirect_s) begin
          state_d = ST_DROP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DROP: begin
        if (bus.imem_rvalid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Redirect wins over the sequential PC and empties the buffer
    if (redirect_s && (state_q != ST_IDLE)) begin
      pc_d    = redirect_tgt_s;
      flush_s = 1'b1;
    end else begin
      flush_s = 1'b0;
    end
  end

  // FIFO bookkeeping plus next values of the registered handshake outputs
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (flush_s) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          wr_ptr_d = ~wr_ptr_q;
          count_d  = count_q + 2'd1;
        end
        2'b01: begin
          rd_ptr_d = ~rd_ptr_q;
          count_d  = count_q - 2'd1;
        end
        2'b11: begin
          wr_ptr_d = ~wr_ptr_q;
          rd_ptr_d = ~rd_ptr_q;
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    // Request only when the buffer has room without relying on a pop
    imem_req_d = (state_d == ST_REQ) && (count_d < 2'd2);
    if_valid_d = (count_d != 2'd0);
  end

  // Control registers: FSM state, PC, FIFO pointers and output flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
    end
  end

  // FIFO storage: write the returned instruction with its address pair
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_instr_q[i] <= {INSTR_W{1'b0}};
        fifo_pc_q[i]    <= {ADDR_W{1'b0}};
        fifo_pc4_q[i]   <= {ADDR_W{1'b0}};
      end
    end else if (push_s) begin
      fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc_q[wr_ptr_q]    <= pc_q;
      fifo_pc4_q[wr_ptr_q]   <= pc_inc_s;
    end else begin
      fifo_instr_q[wr_ptr_q] <= fifo_instr_q[wr_ptr_q];
    end
  end

  // Outputs are taken straight from registers
  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = fifo_instr_q[rd_ptr_q];
  assign bus.if_pc       = fifo_pc_q[rd_ptr_q];
  assign bus.if_pc_plus4 = fifo_pc4_q[rd_ptr_q];

endmodule
